xor_mux_tree_pipe: RTL and testbench

Parametrised, pipelined XOR engine built only from 2:1 mux cells and the constants 0/1. It generalises the single-bit mux-built XOR gate to WIDTH-bit operands. Per transaction it returns the bitwise XOR vector and its parity, optionally inverted to XNOR parity. It is a valid/ready streaming stage for combinational-logic exercises that need a registered, back-pressurable result.

---
 rtl/xor_tree_pkg.sv | 17 +
 rtl/xor_mux_tree_pipe_xor_cell.sv | 33 +++
 rtl/xor_mux_tree_pipe.sv | 112 +++++++++++
 tb/tb_xor_mux_tree_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_tree_pkg.sv
// Shared definitions for the mux-built XOR reduction pipeline.
package xor_tree_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Per-stage sideband carried next to the data of each pipeline stage.
    typedef struct packed {
        logic valid;
        logic inv;
    } side_t;

    // Depth of the pairwise reduction tree for a given operand width.
    function automatic int levels_f(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/xor_mux_tree_pipe_xor_cell.sv
// Mux primitive and the single-bit XOR cell built only from it and constants.

module mux2_cell (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic o
);
    assign o = sel ? d1 : d0;
endmodule

// o = a ? ~b : b, where ~b is itself a mux selecting constant 1/0 on b.
module xor_cell (
    input  logic a,
    input  logic b,
    output logic o
);
    logic not_b;

    mux2_cell u_not_b (
        .sel (b),
        .d0  (1'b1),
        .d1  (1'b0),
        .o   (not_b)
    );

    mux2_cell u_sel (
        .sel (a),
        .d0  (b),
        .d1  (not_b),
        .o   (o)
    );
endmodule

// File: rtl/xor_mux_tree_pipe.sv
// Pipelined WIDTH-bit XOR with registered parity reduction tree.
// Stage 0 registers a^b; each tree level halves the parity operand; the last
// level folds in the XNOR-select flag. All stages stall together.
module xor_mux_tree_pipe
    import xor_tree_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic             out_parity
);
    localparam int LEVELS = levels_f(WIDTH);
    localparam int LAT    = 1 + LEVELS;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
        $error("xor_mux_tree_pipe: WIDTH must be a power of two and at least 2");
    end

    // Tree storage is flattened: level k occupies WIDTH>>k bits starting at
    // WIDTH - (WIDTH>>(k-1)); the single bit of the last level sits at WIDTH-2
    // and already includes the inversion flag.
    logic [WIDTH-1:0] vec_in;
    logic [WIDTH-1:0] vec_r [0:LAT-1];
    side_t            side_r [0:LEVELS-1];
    logic [WIDTH-2:0] tree_r;
    logic [WIDTH-2:0] tree_d;
    logic             out_valid_r;
    logic             advance;

    assign advance = !out_valid_r || out_ready;

    for (genvar i = 0; i < WIDTH; i++) begin : g_in_xor
        xor_cell u_xor (
            .a (in_a[i]),
            .b (in_b[i]),
            .o (vec_in[i])
        );
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N_IN    = WIDTH >> (k - 1);
        localparam int N_OUT   = WIDTH >> k;
        localparam int OFF_OUT = WIDTH - N_IN;

        logic [N_IN-1:0]  src;
        logic [N_OUT-1:0] pair;

        if (k == 1) begin : g_src_vec
            assign src = vec_r[0];
        end else begin : g_src_tree
            assign src = tree_r[OFF_OUT-N_IN +: N_IN];
        end

        for (genvar j = 0; j < N_OUT; j++) begin : g_pair
            xor_cell u_xor (
                .a (src[2*j]),
                .b (src[2*j+1]),
                .o (pair[j])
            );
        end

        if (k == LEVELS) begin : g_last
            xor_cell u_inv (
                .a (pair[0]),
                .b (side_r[LEVELS-1].inv),
                .o (tree_d[WIDTH-2])
            );
        end else begin : g_mid
            assign tree_d[OFF_OUT +: N_OUT] = pair;
        end
    end

    // Global-stall pipeline registers: clear on reset, shift together on advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                vec_r[k] <= '0;
            end
            for (int k = 0; k < LEVELS; k++) begin
                side_r[k] <= '0;
            end
            tree_r      <= '0;
            out_valid_r <= 1'b0;
        end else if (advance) begin
            vec_r[0]  <= vec_in;
            side_r[0] <= side_t'{valid: in_valid, inv: in_inv};
            for (int k = 1; k < LAT; k++) begin
                vec_r[k] <= vec_r[k-1];
            end
            for (int k = 1; k < LEVELS; k++) begin
                side_r[k] <= side_r[k-1];
            end
            tree_r      <= tree_d;
            out_valid_r <= side_r[LEVELS-1].valid;
        end
    end

    assign in_ready   = advance;
    assign out_valid  = out_valid_r;
    assign out_vec    = vec_r[LAT-1];
    assign out_parity = tree_r[WIDTH-2];

endmodule

// File: tb/tb_xor_mux_tree_pipe.sv
// Self-checking bench: WIDTH=8 and WIDTH=2 instances, queue scoreboard.
module tb_xor_mux_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_parity8;
    logic [7:0] in_a8, in_b8, out_vec8;
    logic       in_valid2, in_ready2, in_inv2, out_valid2, out_ready2, out_parity2;
    logic [1:0] in_a2, in_b2, out_vec2;

    xor_mux_tree_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_inv(in_inv8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_vec(out_vec8), .out_parity(out_parity8)
    );

    xor_mux_tree_pipe #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_inv(in_inv2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_vec(out_vec2), .out_parity(out_parity2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       inv;
        logic [7:0] vec;
        logic       par;
    } vec_t;

    typedef struct {
        logic [7:0] vec;
        logic       par;
        int         t;
    } exp_t;

    exp_t       q8[$];
    exp_t       q2[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         lat_chk = 1'b1;
    logic [7:0] pend_vec8;
    logic       pend_par8;
    logic [1:0] pend_vec2;
    logic       pend_par2;

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic inv);
        logic [7:0] v;
        v = a ^ b;
        return {(^v) ^ inv, v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sample mid-cycle: record accepted inputs, compare delivered outputs.
    task automatic tick();
        exp_t e;
        #1;
        if (rst_n) begin
            if (in_valid8 && in_ready8) begin
                e.vec = pend_vec8; e.par = pend_par8; e.t = cyc;
                q8.push_back(e);
            end
            if (in_valid2 && in_ready2) begin
                e.vec = {6'd0, pend_vec2}; e.par = pend_par2; e.t = cyc;
                q2.push_back(e);
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w8_unexpected_output actual vec=%0h required none", out_vec8);
                end else begin
                    e = q8.pop_front();
                    chk("w8_vec", {24'd0, out_vec8}, {24'd0, e.vec});
                    chk("w8_parity", {31'd0, out_parity8}, {31'd0, e.par});
                    if (lat_chk) chk("w8_latency", cyc - e.t, 32'd4);
                end
            end
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w2_unexpected_output actual vec=%0h required none", out_vec2);
                end else begin
                    e = q2.pop_front();
                    chk("w2_vec", {30'd0, out_vec2}, {24'd0, e.vec});
                    chk("w2_parity", {31'd0, out_parity2}, {31'd0, e.par});
                    if (lat_chk) chk("w2_latency", cyc - e.t, 32'd2);
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic inv,
                         input logic [7:0] ev, input logic ep);
        in_valid8 = 1'b1; in_a8 = a; in_b8 = b; in_inv8 = inv;
        pend_vec8 = ev; pend_par8 = ep;
        tick();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        in_valid8 = 1'b0;
        in_valid2 = 1'b0;
        while ((q8.size() != 0 || q2.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (q8.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual pending=%0d required 0", q8.size() + q2.size());
            q8.delete();
            q2.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [8];
        logic [8:0] m;
        logic [8:0] first;
        logic [7:0] ra, rb;
        logic       ri;
        int         n;

        tbl[0] = '{a: 8'hA5, b: 8'h0F, inv: 1'b0, vec: 8'hAA, par: 1'b0};
        tbl[1] = '{a: 8'h01, b: 8'h00, inv: 1'b0, vec: 8'h01, par: 1'b1};
        tbl[2] = '{a: 8'h01, b: 8'h00, inv: 1'b1, vec: 8'h01, par: 1'b0};
        tbl[3] = '{a: 8'hFF, b: 8'h00, inv: 1'b0, vec: 8'hFF, par: 1'b0};
        tbl[4] = '{a: 8'hFF, b: 8'hFF, inv: 1'b1, vec: 8'h00, par: 1'b1};
        tbl[5] = '{a: 8'h80, b: 8'h00, inv: 1'b0, vec: 8'h80, par: 1'b1};
        tbl[6] = '{a: 8'h3C, b: 8'hC3, inv: 1'b1, vec: 8'hFF, par: 1'b1};
        tbl[7] = '{a: 8'h12, b: 8'h34, inv: 1'b0, vec: 8'h26, par: 1'b1};

        rst_n = 1'b0;
        in_valid8 = 1'b0; in_a8 = 8'h00; in_b8 = 8'h00; in_inv8 = 1'b0; out_ready8 = 1'b1;
        in_valid2 = 1'b0; in_a2 = 2'd0; in_b2 = 2'd0; in_inv2 = 1'b0; out_ready2 = 1'b1;
        pend_vec8 = 8'h00; pend_par8 = 1'b0; pend_vec2 = 2'd0; pend_par2 = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid8", {31'd0, out_valid8}, 32'd0);
        chk("reset_out_vec8", {24'd0, out_vec8}, 32'd0);
        chk("reset_out_parity8", {31'd0, out_parity8}, 32'd0);
        chk("reset_in_ready8", {31'd0, in_ready8}, 32'd1);
        chk("reset_out_valid2", {31'd0, out_valid2}, 32'd0);

        // Single transaction, exact latency, one-cycle valid pulse.
        send8(8'hA5, 8'h0F, 1'b0, 8'hAA, 1'b0);
        drain(10);
        #1;
        chk("single_pulse_out_valid", {31'd0, out_valid8}, 32'd0);

        // Table vectors back to back.
        for (int i = 0; i < 8; i++) begin
            send8(tbl[i].a, tbl[i].b, tbl[i].inv, tbl[i].vec, tbl[i].par);
        end
        drain(20);

        // 16 random back-to-back transactions.
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); ri = 1'($urandom);
            m = model8(ra, rb, ri);
            send8(ra, rb, ri, m[7:0], m[8]);
        end
        drain(30);

        // Backpressure: four in flight, output held for three cycles.
        lat_chk = 1'b0;
        out_ready8 = 1'b0;
        first = model8(8'h10, 8'h03, 1'b0);
        for (int i = 0; i < 4; i++) begin
            m = model8(8'h10 + 8'(i), 8'h03, 1'(i));
            send8(8'h10 + 8'(i), 8'h03, 1'(i), m[7:0], m[8]);
        end
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 10) begin
            tick();
            n++;
        end
        chk("stall_fill_out_valid", {31'd0, out_valid8}, 32'd1);
        for (int s = 0; s < 3; s++) begin
            in_valid8 = 1'b1; in_a8 = 8'hEE; in_b8 = 8'h11; in_inv8 = 1'b0;
            pend_vec8 = 8'hFF; pend_par8 = 1'b0;
            #1;
            chk("stall_in_ready", {31'd0, in_ready8}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid8}, 32'd1);
            chk("stall_out_vec", {24'd0, out_vec8}, {24'd0, first[7:0]});
            chk("stall_out_parity", {31'd0, out_parity8}, {31'd0, first[8]});
            tick();
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        drain(20);
        lat_chk = 1'b1;

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            m = model8(8'h55, 8'(i), 1'b0);
            send8(8'h55, 8'(i), 1'b0, m[7:0], m[8]);
        end
        rst_n = 1'b0;
        in_valid8 = 1'b1; in_a8 = 8'hC0; in_b8 = 8'h01; in_inv8 = 1'b1;
        tick();
        q8.delete();
        rst_n = 1'b1;
        in_valid8 = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid8}, 32'd0);
        chk("rst_mid_out_vec", {24'd0, out_vec8}, 32'd0);
        chk("rst_mid_out_parity", {31'd0, out_parity8}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready8}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("rst_no_stale", {31'd0, out_valid8}, 32'd0);
            tick();
        end
        send8(8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b1);
        drain(10);

        // WIDTH=2 exhaustive.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int v = 0; v < 2; v++) begin
                    in_valid2 = 1'b1; in_a2 = 2'(a); in_b2 = 2'(b); in_inv2 = 1'(v);
                    pend_vec2 = 2'(a) ^ 2'(b);
                    pend_par2 = (^(2'(a) ^ 2'(b))) ^ 1'(v);
                    tick();
                end
            end
        end
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
